// File: rtl/pwm_gate_pkg.sv
// PWM gate controller shared types and defaults.
// Channel FSM state encoding and default parameter values.
package pwm_gate_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARM   = 2'd1,
    ON    = 2'd2,
    DRAIN = 2'd3
  } ch_state_t;

  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_WDOG_CYCLES = 50000000;

endpackage

// File: rtl/pwm_gate_ch.sv
// Single PWM gate channel: 4-state FSM plus registered output.
// Gate changes only take effect at pulse boundaries.
import pwm_gate_pkg::*;

module pwm_gate_ch (
  input  logic clk,
  input  logic rst,
  input  logic en_eff,
  input  logic pwm_i,
  output logic pwm_o,
  output logic active
);

  ch_state_t state;

  assign active = (state == ON) || (state == DRAIN);

  // Gate FSM and output register; output follows source only when passing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= active & pwm_i;
      unique case (state)
        OFF: begin
          if (en_eff)
            state <= pwm_i ? ARM : ON;
        end
        ARM: begin
          if (!en_eff)
            state <= OFF;
          else if (!pwm_i)
            state <= ON;
        end
        ON: begin
          if (!en_eff)
            state <= pwm_i ? DRAIN : OFF;
        end
        DRAIN: begin
          if (!pwm_i)
            state <= OFF;
          else if (en_eff)
            state <= ON;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_gate_ctrl.sv
// Multi-channel PWM gate controller with optional watchdog.
// Define PWM_GATE_WDOG_EN to build the watchdog counter.
import pwm_gate_pkg::*;

module pwm_gate_ctrl #(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] move_en,
  input  logic [NUM_CH-1:0] pwm_i,
  input  logic              kick,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] ch_active,
  output logic              wdog_trip
);

`ifdef PWM_GATE_WDOG_EN
  localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] wdog_cnt;

  // Free-running timeout counter; kick wins over expiry, trip is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (kick) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (wdog_cnt != CNT_LAST) begin
      wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt + 1'b1 == CNT_LAST)
        wdog_trip <= 1'b1;
    end
  end
`else
  logic unused_kick;
  assign unused_kick = kick;
  assign wdog_trip   = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_gate_ch u_ch (
      .clk    (clk),
      .rst    (rst),
      .en_eff (move_en[g] & ~wdog_trip),
      .pwm_i  (pwm_i[g]),
      .pwm_o  (pwm_o[g]),
      .active (ch_active[g])
    );
  end

endmodule

// File: tb/tb_pwm_gate_ctrl.sv
// Directed bench for pwm_gate_ctrl, two channels.
// Watchdog checks follow the PWM_GATE_WDOG_EN build setting.
module tb_pwm_gate_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] move_en;
  logic [1:0] pwm_i;
  logic       kick;
  logic [1:0] pwm_o;
  logic [1:0] ch_active;
  logic       wdog_trip;

  int n_chk = 0;
  int n_err = 0;
  int highs;

  pwm_gate_ctrl #(
    .NUM_CH      (2),
    .WDOG_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .move_en   (move_en),
    .pwm_i     (pwm_i),
    .kick      (kick),
    .pwm_o     (pwm_o),
    .ch_active (ch_active),
    .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] en, input logic [1:0] pw);
    move_en = en;
    pwm_i   = pw;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    move_en = 2'b00;
    pwm_i   = 2'b00;
    kick    = 1'b1;
    #2;
    check("rst_pwm_o", 32'(pwm_o), 0);
    check("rst_active", 32'(ch_active), 0);
    check("rst_trip", 32'(wdog_trip), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // enable rises mid-pulse: ARM, then whole next pulse
    cyc(2'b00, 2'b01);
    check("off_hold", 32'(ch_active), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b01);
      check($sformatf("arm_act%0d", i), 32'(ch_active), 0);
      check($sformatf("arm_out%0d", i), 32'(pwm_o), 0);
    end
    cyc(2'b01, 2'b00);
    check("arm_to_on", 32'(ch_active), 32'h1);
    check("on_low", 32'(pwm_o), 0);
    cyc(2'b01, 2'b01);
    check("pulse_a", 32'(pwm_o), 32'h1);
    cyc(2'b01, 2'b01);
    check("pulse_b", 32'(pwm_o), 32'h1);
    cyc(2'b01, 2'b00);
    check("pulse_end", 32'(pwm_o), 0);

    // disable 2 cycles into an 8-cycle pulse: drain whole pulse
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc((i < 2) ? 2'b01 : 2'b00, 2'b01);
      if (pwm_o[0]) highs++;
    end
    check("drain_highs", 32'(highs), 8);
    check("drain_act", 32'(ch_active), 32'h1);
    cyc(2'b00, 2'b00);
    check("drain_off", 32'(ch_active), 0);
    check("drain_out", 32'(pwm_o), 0);
    cyc(2'b00, 2'b01);
    check("off_block", 32'(pwm_o), 0);

    // two channels, opposite phases, same-cycle gate changes
    cyc(2'b00, 2'b00);
    cyc(2'b11, 2'b10);
    check("dual_en_act", 32'(ch_active), 32'h1);
    check("dual_en_out", 32'(pwm_o), 0);
    cyc(2'b11, 2'b01);
    check("dual_on_act", 32'(ch_active), 32'h3);
    check("dual_on_out", 32'(pwm_o), 32'h1);
    cyc(2'b00, 2'b01);
    check("dual_dis_act", 32'(ch_active), 32'h1);
    check("dual_dis_out", 32'(pwm_o), 32'h1);
    cyc(2'b00, 2'b00);
    check("dual_off_act", 32'(ch_active), 0);
    check("dual_off_out", 32'(pwm_o), 0);

    // async reset during a high output
    cyc(2'b01, 2'b00);
    cyc(2'b01, 2'b01);
    check("pre_rst_out", 32'(pwm_o), 32'h1);
    rst = 1'b1;
    #1;
    check("async_out", 32'(pwm_o), 0);
    check("async_act", 32'(ch_active), 0);
    move_en = 2'b00;
    pwm_i   = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_act", 32'(ch_active), 0);
    cyc(2'b01, 2'b00);
    check("first_edge", 32'(ch_active), 32'h1);

`ifdef PWM_GATE_WDOG_EN
    // 16-cycle watchdog with no kick
    kick = 1'b0;
    do_reset();
    for (int i = 0; i < 14; i++)
      cyc(2'b01, 2'b00);
    check("wd_pre_trip", 32'(wdog_trip), 0);
    check("wd_pre_act", 32'(ch_active), 32'h1);
    cyc(2'b01, 2'b00);
    check("wd_trip", 32'(wdog_trip), 32'h1);
    cyc(2'b01, 2'b00);
    check("wd_drained", 32'(ch_active), 0);
    check("wd_sticky", 32'(wdog_trip), 32'h1);
    kick = 1'b1;
    cyc(2'b01, 2'b00);
    check("wd_kick_clr", 32'(wdog_trip), 0);
    cyc(2'b01, 2'b00);
    check("wd_rearm", 32'(ch_active), 32'h1);
`else
    // kick ignored: never trips, gating unaffected
    kick = 1'b0;
    do_reset();
    for (int i = 0; i < 200; i++)
      cyc(2'b01, (i % 4 == 1) ? 2'b01 : 2'b00);
    check("nowd_trip", 32'(wdog_trip), 0);
    check("nowd_act", 32'(ch_active), 32'h1);
    check("nowd_out", 32'(pwm_o), 0);
    cyc(2'b01, 2'b01);
    check("nowd_pass", 32'(pwm_o), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_gate_ctrl.md
PWM_GATE_CTRL -- requirements
Module: pwm_gate_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent PWM channels (1..16).
REQ-002 The block SHALL have parameter WDOG_CYCLES, default 50000000, giving the watchdog timeout in clk cycles (>=2).
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 move_en  input  NUM_CH  per-channel enable request, 1 = pass PWM.
REQ-006 pwm_i  input  NUM_CH  per-channel PWM source, synchronous to clk.
REQ-007 kick  input  1  watchdog refresh, single-cycle pulse or level.
REQ-008 pwm_o  output  NUM_CH  gated PWM, registered.
REQ-009 ch_active  output  NUM_CH  1 when the channel state is ON or DRAIN.
REQ-010 wdog_trip  output  1  sticky watchdog-expired flag.

Function
REQ-011 Each channel SHALL implement a 4-state FSM: OFF, ARM, ON, DRAIN; en_eff[i] = move_en[i] & ~wdog_trip.
REQ-012 From OFF, the FSM SHALL move to ON if en_eff=1 and pwm_i=0, to ARM if en_eff=1 and pwm_i=1, and otherwise stay in OFF.
REQ-013 From ARM, the FSM SHALL move to OFF if en_eff=0, to ON if en_eff=1 and pwm_i=0, and otherwise stay in ARM.
REQ-014 From ON, the FSM SHALL move to OFF if en_eff=0 and pwm_i=0, to DRAIN if en_eff=0 and pwm_i=1, and otherwise stay in ON.
REQ-015 From DRAIN, the FSM SHALL move to OFF if pwm_i=0, to ON if en_eff=1 and pwm_i=1, and otherwise stay in DRAIN.
REQ-016 At each clk edge, pwm_o[i] SHALL load pwm_i[i] if the current state is ON or DRAIN, and 0 otherwise (1-cycle latency).
REQ-017 Consequence of REQ-012..016: a gate change never truncates or splits a pulse; only whole high pulses reach pwm_o.
REQ-018 ch_active[i] SHALL be combinational from the state register: 1 in ON or DRAIN.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on several channels are legal.
REQ-020 pwm_i held constantly high with enable SHALL leave the channel in ARM indefinitely, with pwm_o=0.
REQ-021 pwm_i held constantly high after disable SHALL leave the channel in DRAIN, passing 1, until pwm_i falls.

Reset
REQ-022 While rst=1, the block SHALL hold every channel in OFF, pwm_o=0, ch_active=0, the watchdog counter at 0 and wdog_trip=0, asynchronously.
REQ-023 Reset asserted mid-pulse SHALL force pwm_o low immediately; this is the only permitted truncation.
REQ-024 After rst deasserts, normal operation SHALL start on the first clk edge.

Configuration
REQ-025 Macro PWM_GATE_WDOG_EN SHALL compile in a watchdog counter that increments each cycle, clears to 0 on kick=1, and sets wdog_trip on the cycle it reaches WDOG_CYCLES-1.
REQ-026 With PWM_GATE_WDOG_EN, kick=1 SHALL clear wdog_trip; kick has priority over expiry in the same cycle.
REQ-027 With PWM_GATE_WDOG_EN, a trip SHALL drain channels gracefully per REQ-014/015, not cut them.
REQ-028 Without PWM_GATE_WDOG_EN, the counter SHALL be absent, the kick port SHALL remain but be ignored, and wdog_trip SHALL be tied to 0.

Structure
REQ-029 Shared package pwm_gate_pkg SHALL hold:
  - the state typedef: OFF=2'd0, ARM=2'd1, ON=2'd2, DRAIN=2'd3;
  - default parameter constants.
REQ-030 Per-channel FSM and output register SHALL live in sub-module pwm_gate_ch, instantiated NUM_CH times via generate.
REQ-031 The watchdog SHALL live in the top level, inside the macro guard.

Verification
REQ-032 move_en[0] rises while pwm_i[0] is high for 3 more cycles -> ARM for 3 cycles, pwm_o[0]=0, then ON; the next full pulse appears delayed 1 cycle.
REQ-033 move_en[0] falls 2 cycles into an 8-cycle high pulse -> DRAIN, all 8 high cycles appear on pwm_o[0], then OFF.
REQ-034 Channels 0 and 1 are enabled/disabled on the same cycle with opposite pwm_i phases -> each follows its own FSM path; no cross-coupling.
REQ-035 With PWM_GATE_WDOG_EN, WDOG_CYCLES=16 and no kick:
  - wdog_trip=1 on cycle 15;
  - channels drain to OFF;
  - a kick clears the trip and re-arms the channels.
REQ-036 rst pulses during a high pwm_o -> pwm_o=0 with no clk edge, and all channels are in OFF after rst falls.
REQ-037 Without the macro, kick is never asserted for 10^6 cycles -> wdog_trip stays 0 and gating is unaffected.
